// File: rtl/ext_intr_collector.sv
// ext_intr_collector
//   Gathers done/event pulses from external coprocessors into sticky,
//   maskable interrupt lines for the system's external interrupt vector.
//   Firmware services the block through a zero-wait-state register-bus slave.
//
//   Register map (addr[3:2], bits >= NUM_SRC read 0 and ignore writes):
//     0x0 PENDING  RW1C  sticky captured events
//     0x4 ENABLE   RW    interrupt mask
//     0x8 MODE     RW    1 = rising-edge capture, 0 = level capture
//     0xC OVERFLOW RW1C  edge arrived while PENDING was already set
//   Any address with addr[31:4] != 0 answers error=1, rdata=0, no side effects.
//
//   Ports:
//     clk_i      system clock
//     rst_i      asynchronous active-high reset
//     src_i      raw event inputs, one bit per source
//     reg_req_i  register-bus request
//     reg_rsp_o  register-bus response (ready = valid, combinational rdata)
//     intr_o     PENDING & ENABLE
//     irq_any_o  OR-reduction of intr_o
//
//   Build option: define EXT_INTR_SYNC_EN to pass every src_i bit through a
//   2-flop synchroniser before edge detection (adds 2 cycles of latency).

package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module ext_intr_collector #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  reg_pkg::reg_req_t  reg_req_i,
  output reg_pkg::reg_rsp_t  reg_rsp_o,
  output logic [NUM_SRC-1:0] intr_o,
  output logic               irq_any_o
);

  typedef enum logic [1:0] {
    REG_PENDING  = 2'd0,
    REG_ENABLE   = 2'd1,
    REG_MODE     = 2'd2,
    REG_OVERFLOW = 2'd3
  } reg_sel_e;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] src_s;

  logic               addr_ok;
  logic               wr_en;
  reg_sel_e           sel;
  logic [31:0]        wmask;
  logic [NUM_SRC-1:0] wsel;
  logic [NUM_SRC-1:0] wbits;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cap_set;
  logic [NUM_SRC-1:0] ovf_set;
  logic [NUM_SRC-1:0] rdata_sel;
  logic               unused_bits;

`ifdef EXT_INTR_SYNC_EN
  logic [NUM_SRC-1:0] src_meta_q, src_meta_d;
  logic [NUM_SRC-1:0] src_sync_q, src_sync_d;

  always_comb begin
    src_meta_d = src_i;
    src_sync_d = src_meta_q;
    src_s      = src_sync_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_meta_q <= '0;
      src_sync_q <= '0;
    end else begin
      src_meta_q <= src_meta_d;
      src_sync_q <= src_sync_d;
    end
  end
`else
  always_comb src_s = src_i;
`endif

  // Byte offset and wdata bits above NUM_SRC carry no state.
  always_comb unused_bits = ^{reg_req_i.addr[1:0], reg_req_i.wdata};

  always_comb begin
    addr_ok = (reg_req_i.addr[31:4] == '0);
    wr_en   = reg_req_i.valid & reg_req_i.write & addr_ok;
    sel     = reg_sel_e'(reg_req_i.addr[3:2]);

    wmask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      wmask[b*8 +: 8] = {8{reg_req_i.wstrb[b]}};
    end
    wsel  = wmask[NUM_SRC-1:0];
    wbits = reg_req_i.wdata[NUM_SRC-1:0] & wsel;

    // src_q tracks in both modes, so a mode switch never sees a stale edge.
    rise    = src_s & ~src_q;
    cap_set = (mode_q & rise) | (~mode_q & src_s);
    ovf_set = mode_q & rise & pending_q;
    src_d   = src_s;

    pending_d  = pending_q;
    enable_d   = enable_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      unique case (sel)
        REG_PENDING:  pending_d  = pending_q & ~wbits;
        REG_ENABLE:   enable_d   = (enable_q & ~wsel) | wbits;
        REG_MODE:     mode_d     = (mode_q & ~wsel) | wbits;
        REG_OVERFLOW: overflow_d = overflow_q & ~wbits;
      endcase
    end
    // Capture is applied after the W1C so a same-cycle set wins.
    pending_d  = pending_d | cap_set;
    overflow_d = overflow_d | ovf_set;
  end

  always_comb begin
    unique case (sel)
      REG_PENDING:  rdata_sel = pending_q;
      REG_ENABLE:   rdata_sel = enable_q;
      REG_MODE:     rdata_sel = mode_q;
      REG_OVERFLOW: rdata_sel = overflow_q;
    endcase

    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    if (addr_ok) begin
      reg_rsp_o.rdata[NUM_SRC-1:0] = rdata_sel;
    end else begin
      reg_rsp_o.error = reg_req_i.valid;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '1;
      overflow_q <= '0;
      src_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
      src_q      <= src_d;
    end
  end

  always_comb begin
    intr_o    = pending_q & enable_q;
    irq_any_o = |intr_o;
  end

endmodule

// File: tb/tb_ext_intr_collector.sv
module tb_ext_intr_collector;
  localparam int unsigned N = 4;
`ifdef EXT_INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      src = '0;
  reg_pkg::reg_req_t req = '0;
  reg_pkg::reg_rsp_t rsp;
  logic [N-1:0]      intr;
  logic              irq_any;

  int total = 0;
  int bad   = 0;

  // Reference state: what firmware would see, plus the source history the
  // rules need (previous sampled value and synchroniser delay line).
  logic [N-1:0] m_pend, m_en, m_mode, m_ovf, m_prev, m_s1, m_s2;

  always #5 clk = ~clk;

  ext_intr_collector #(.NUM_SRC(N)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .src_i    (src),
    .reg_req_i(req),
    .reg_rsp_o(rsp),
    .intr_o   (intr),
    .irq_any_o(irq_any)
  );

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '1; m_ovf = '0;
    m_prev = '0; m_s1 = '0; m_s2 = '0;
  endtask

  // Advance one clock, updating the reference from the inputs present now.
  task automatic tick();
    logic [N-1:0] s, np, ne, nm, no, wm, wd;
    logic         rising, hit;
`ifdef EXT_INTR_SYNC_EN
    s = m_s2;
`else
    s = src;
`endif
    np = m_pend; ne = m_en; nm = m_mode; no = m_ovf;
    for (int i = 0; i < int'(N); i++) begin
      wm[i] = req.wstrb[i/8];
      wd[i] = req.wdata[i] & wm[i];
    end
    if (req.valid && req.write && req.addr[31:4] == 28'd0) begin
      case (req.addr[3:2])
        2'd0: np = np & ~wd;
        2'd1: ne = (ne & ~wm) | wd;
        2'd2: nm = (nm & ~wm) | wd;
        default: no = no & ~wd;
      endcase
    end
    for (int i = 0; i < int'(N); i++) begin
      rising = s[i] && !m_prev[i];
      hit    = m_mode[i] ? rising : s[i];
      if (hit) np[i] = 1'b1;
      if (m_mode[i] && rising && m_pend[i]) no[i] = 1'b1;
    end
    @(posedge clk);
    m_pend = np; m_en = ne; m_mode = nm; m_ovf = no;
    m_prev = s; m_s2 = m_s1; m_s1 = src;
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    req.valid = 1'b1; req.write = 1'b1; req.addr = addr;
    req.wdata = data; req.wstrb = strb;
    tick();
    req = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d,
                          output logic err, output logic rdy);
    @(negedge clk);
    req = '0; req.valid = 1'b1; req.addr = addr;
    #1;
    d = rsp.rdata; err = rsp.error; rdy = rsp.ready;
    req = '0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src = src | m;
    tick();
    src = src & ~m;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, r;
    do_reset();
    total++; if (intr !== 4'h0) begin bad++; $display("FAIL reset_intr got=%h exp=0", intr); end
    total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_any); end
    total++; if (rsp.ready !== 1'b0 || rsp.error !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b exp=00", rsp.ready, rsp.error); end
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h0 || e !== 1'b0 || r !== 1'b1) begin bad++; $display("FAIL reset_pending got=%h e=%b r=%b exp=0", d, e, r); end
    bus_read(32'h4, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_enable got=%h exp=0", d); end
    bus_read(32'h8, d, e, r);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL reset_mode got=%h exp=f", d); end
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_overflow got=%h exp=0", d); end
  endtask

  task automatic test_edge_capture();
    logic [31:0] d; logic e, r;
    bus_write(32'h4, 32'h1, 4'hF);
    repeat (5) tick();
    total++; if (intr !== 4'h0) begin bad++; $display("FAIL edge_idle got=%h exp=0", intr); end
    pulse(4'h1);
    repeat (LAT) tick();
    total++; if (intr !== 4'h1 || irq_any !== 1'b1) begin bad++; $display("FAIL edge_intr got=%h/%b exp=1/1", intr, irq_any); end
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL edge_pending got=%h exp=1", d); end
    bus_write(32'h0, 32'h1, 4'hF);
    total++; if (intr !== 4'h0 || irq_any !== 1'b0) begin bad++; $display("FAIL edge_clear got=%h/%b exp=0/0", intr, irq_any); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic e, r;
    pulse(4'h2);
    repeat (10) tick();
    pulse(4'h2);
    repeat (LAT) tick();
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_pending got=%h exp=2", d); end
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_flag got=%h exp=2", d); end
    bus_write(32'hC, 32'h2, 4'hF);
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovf_clear got=%h exp=0", d); end
    bus_write(32'h0, 32'hF, 4'hF);
  endtask

  task automatic test_collision();
    logic [31:0] d; logic e, r;
    pulse(4'h4);
    repeat (LAT + 1) tick();
    src[2] = 1'b1;
    repeat (LAT) tick();
    bus_write(32'h0, 32'h4, 4'hF);
    src[2] = 1'b0;
    bus_read(32'h0, d, e, r);
    total++; if (d[2] !== 1'b1) begin bad++; $display("FAIL collide_pending got=%h exp=bit2 set", d); end
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL collide_overflow got=%h exp=4", d); end
    bus_write(32'h0, 32'hF, 4'hF);
    bus_write(32'hC, 32'hF, 4'hF);
  endtask

  task automatic test_level_mode();
    logic [31:0] d; logic e, r;
    bus_write(32'h8, 32'hE, 4'hF);
    bus_write(32'h4, 32'h1, 4'hF);
    src[0] = 1'b1;
    repeat (9) tick();
    bus_write(32'h0, 32'h1, 4'hF);
    bus_read(32'h0, d, e, r);
    total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL level_mid got=%h exp=bit0 set", d); end
    repeat (10) tick();
    total++; if (intr !== 4'h1) begin bad++; $display("FAIL level_intr got=%h exp=1", intr); end
    src[0] = 1'b0;
    repeat (LAT + 2) tick();
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL level_sticky got=%h exp=1", d); end
    bus_write(32'h0, 32'h1, 4'hF);
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h0 || intr !== 4'h0) begin bad++; $display("FAIL level_clear got=%h/%h exp=0/0", d, intr); end
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL level_overflow got=%h exp=0", d); end
  endtask

  task automatic test_mask_bus();
    logic [31:0] d; logic e, r;
    bus_write(32'h4, 32'h0, 4'hF);
    bus_write(32'h8, 32'hF, 4'hF);
    pulse(4'h8);
    repeat (LAT) tick();
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL mask_pending got=%h exp=8", d); end
    total++; if (intr !== 4'h0 || irq_any !== 1'b0) begin bad++; $display("FAIL mask_intr got=%h/%b exp=0/0", intr, irq_any); end
    bus_write(32'h4, 32'h8, 4'hF);
    total++; if (intr !== 4'h8 || irq_any !== 1'b1) begin bad++; $display("FAIL mask_enable got=%h/%b exp=8/1", intr, irq_any); end
    bus_read(32'h10, d, e, r);
    total++; if (e !== 1'b1 || d !== 32'h0 || r !== 1'b1) begin bad++; $display("FAIL bad_addr got=%h e=%b r=%b exp=0/1/1", d, e, r); end
    bus_write(32'h14, 32'h0, 4'hF);
    bus_write(32'h4, 32'h0, 4'hE);
    bus_read(32'h4, d, e, r);
    total++; if (d !== 32'h8 || e !== 1'b0) begin bad++; $display("FAIL enable_kept got=%h e=%b exp=8/0", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d, a; logic e, r;
    for (int it = 0; it < 400; it++) begin
      src = N'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        a = 32'($urandom_range(0, 3)) << 2;
        bus_write(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        tick();
      end
      total++;
      if (intr !== (m_pend & m_en) || irq_any !== |(m_pend & m_en)) begin
        bad++; $display("FAIL rand_intr it=%0d got=%h/%b exp=%h", it, intr, irq_any, m_pend & m_en);
      end
      if (it % 40 == 39) begin
        bus_read(32'h0, d, e, r);
        total++; if (d !== {28'd0, m_pend}) begin bad++; $display("FAIL rand_pending got=%h exp=%h", d, m_pend); end
        bus_read(32'h4, d, e, r);
        total++; if (d !== {28'd0, m_en}) begin bad++; $display("FAIL rand_enable got=%h exp=%h", d, m_en); end
        bus_read(32'h8, d, e, r);
        total++; if (d !== {28'd0, m_mode}) begin bad++; $display("FAIL rand_mode got=%h exp=%h", d, m_mode); end
        bus_read(32'hC, d, e, r);
        total++; if (d !== {28'd0, m_ovf}) begin bad++; $display("FAIL rand_overflow got=%h exp=%h", d, m_ovf); end
      end
    end
    src = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic e, r;
    bus_write(32'h8, 32'hF, 4'hF);
    bus_write(32'h4, 32'hF, 4'hF);
    bus_write(32'h0, 32'hF, 4'hF);
    pulse(4'hF);
    repeat (LAT) tick();
    total++; if (intr !== 4'hF) begin bad++; $display("FAIL arst_pre got=%h exp=f", intr); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++; if (intr !== 4'h0 || irq_any !== 1'b0) begin bad++; $display("FAIL arst_intr got=%h/%b exp=0/0", intr, irq_any); end
    bus_read(32'h0, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL arst_pending got=%h exp=0", d); end
    bus_read(32'h4, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL arst_enable got=%h exp=0", d); end
    bus_read(32'h8, d, e, r);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL arst_mode got=%h exp=f", d); end
    bus_read(32'hC, d, e, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL arst_overflow got=%h exp=0", d); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge_capture();
    test_overflow();
    test_collision();
    test_level_mode();
    test_mask_bus();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
